// File: rtl/mux_pipe_n_pkg.sv
// Shared widths and helpers for the N:1 pipelined select mux.
// sel_w() gives the select width, never below 1.
package mux_pipe_n_pkg;

  localparam int WORD_W    = 32;
  localparam int REGADDR_W = 5;

  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_pipe_n_if.sv
// Handshake bundle for mux_pipe_n: input side, output side, flush.
// master drives in_*/sel/flush/out_ready; slave is the mux.
interface mux_pipe_n_if
  import mux_pipe_n_pkg::*;
#(
  parameter int W    = WORD_W,
  parameter int N    = 4,
  parameter int SELW = sel_w(N)
) ();

  logic [N*W-1:0]  in_data;
  logic [SELW-1:0] sel;
  logic            in_valid;
  logic            in_ready;
  logic            flush;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_sel;
  logic            out_valid;
  logic            out_ready;
  logic            sel_err;

  modport master (
    output in_data, sel, in_valid,
    output flush, out_ready,
    input  in_ready, out_data, out_sel,
    input  out_valid, sel_err
  );

  modport slave (
    input  in_data, sel, in_valid,
    input  flush, out_ready,
    output in_ready, out_data, out_sel,
    output out_valid, sel_err
  );

endinterface

// File: rtl/mux_n_comb.sv
// Combinational N:1 slice select; word k = in_data[k*W +: W].
// Ports: in_data, sel in; out_data (0 when sel >= N), oor flag out.
module mux_n_comb #(
  parameter int W    = 32,
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic [N*W-1:0]  in_data,
  input  logic [SELW-1:0] sel,
  output logic [W-1:0]    out_data,
  output logic            oor
);

  always_comb begin
    out_data = '0;
    oor      = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (sel == SELW'(k)) begin
        out_data = in_data[k*W +: W];
        oor      = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_pipe_n.sv
// Registered N:1 mux with valid/ready, flush and sticky sel_err.
// Ports: clk, rst (async high), bus (mux_pipe_n_if.slave).
// MUX_PIPE_SKID_EN adds a one-word skid so in_ready comes from a flop.
module mux_pipe_n
  import mux_pipe_n_pkg::*;
#(
  parameter int W    = WORD_W,
  parameter int N    = 4,
  localparam int SELW = sel_w(N)
) (
  input logic          clk,
  input logic          rst,
  mux_pipe_n_if.slave  bus
);

  logic [W-1:0]    mux_data;
  logic            mux_oor;
  logic            rdy;
  logic            acc;
  logic            out_valid_q;
  logic [W-1:0]    out_data_q;
  logic [SELW-1:0] out_sel_q;
  logic            sel_err_q;

  mux_n_comb #(
    .W    (W),
    .N    (N),
    .SELW (SELW)
  ) u_mux (
    .in_data  (bus.in_data),
    .sel      (bus.sel),
    .out_data (mux_data),
    .oor      (mux_oor)
  );

  assign acc           = bus.in_valid && rdy;
  assign bus.in_ready  = rdy;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.sel_err   = sel_err_q;

  // A flushed word never counts as accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sel_err_q <= 1'b0;
    else if (acc && !bus.flush && mux_oor)
      sel_err_q <= 1'b1;
  end

`ifdef MUX_PIPE_SKID_EN

  logic            skid_valid;
  logic [W-1:0]    skid_data;
  logic [SELW-1:0] skid_sel;

  assign rdy = !rst && !skid_valid;

  // Skid only fills while the output is stalled, so
  // skid_valid implies out_valid and order is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      skid_valid  <= 1'b0;
      skid_data   <= '0;
      skid_sel    <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
      skid_valid  <= 1'b0;
    end else if (!out_valid_q || bus.out_ready) begin
      if (skid_valid) begin
        out_valid_q <= 1'b1;
        out_data_q  <= skid_data;
        out_sel_q   <= skid_sel;
        skid_valid  <= 1'b0;
      end else if (acc) begin
        out_valid_q <= 1'b1;
        out_data_q  <= mux_data;
        out_sel_q   <= bus.sel;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (acc) begin
      skid_valid <= 1'b1;
      skid_data  <= mux_data;
      skid_sel   <= bus.sel;
    end
  end

`else

  assign rdy = !rst && (!out_valid_q || bus.out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (acc) begin
      out_valid_q <= 1'b1;
      out_data_q  <= mux_data;
      out_sel_q   <= bus.sel;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`endif

endmodule
